// File: rtl/vproc_mem_responder_if.sv
// ---------------------------------------------------------------------------
// vproc_mem_responder_if
// Request/response bus between a vector-processor memory port (master) and
// the vproc_mem_responder storage model (slave). Signal names carry the
// direction as seen from the responder.
//   mem_req_i    request valid, accepted every cycle it is high
//   mem_addr_i   byte address, bits [1:0] ignored
//   mem_we_i     1 = write, 0 = read
//   mem_be_i     byte enables for writes
//   mem_wdata_i  write data
//   mem_rvalid_o response valid (reads and writes)
//   mem_err_o    response error, meaningful only with mem_rvalid_o
//   mem_rdata_o  read data, 0 for writes and errors
// ---------------------------------------------------------------------------
interface vproc_mem_responder_if;
  logic        mem_req_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i;
  logic        mem_rvalid_o;
  logic        mem_err_o;
  logic [31:0] mem_rdata_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    input  mem_rvalid_o, mem_err_o, mem_rdata_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    output mem_rvalid_o, mem_err_o, mem_rdata_o
  );
endinterface

// File: rtl/vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// vproc_mem_responder
// Fixed-latency word memory that answers every request (no grant, no
// backpressure). Writes and read sampling happen on the accepting edge; the
// response {valid, err, rdata} travels through a LATENCY-deep shift pipeline
// so responses come out in request order with no gaps.
//
// Parameters
//   MEM_W     data word width (only 32 supported)
//   MEM_SZ    storage size in bytes, power of two
//   LATENCY   request-to-response delay in cycles, 1..4
//   BASE_ADDR byte address of storage word 0
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset (storage is not cleared)
//   mem       request/response bus, slave side
//   done_o    sticky flag, set when a request to offset 0 is accepted
// Build option
//   VPROC_MEM_RESP_ERR_EN  when defined, requests whose offset lies outside
//                          the storage return err=1, rdata=0 and never write;
//                          when undefined, addresses alias modulo MEM_SZ and
//                          mem_err_o is constant 0.
// ---------------------------------------------------------------------------
module vproc_mem_responder #(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned MEM_SZ    = 4096,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vproc_mem_responder_if.slave mem,
  output logic                 done_o
);

`ifdef VPROC_MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int unsigned IDX_W = $clog2(MEM_SZ);
  localparam int unsigned WORDS = MEM_SZ / 32'd4;

  // Storage: deliberately has no reset so contents survive rst_ni.
  logic [MEM_W-1:0] mem_q [WORDS];

  logic [31:0]      offset_s;
  logic [IDX_W-3:0] idx_s;
  logic             oor_s;
  logic             wr_en_s;
  logic             unused_s;

  logic             rsp_err_d;
  logic [MEM_W-1:0] rsp_rdata_d;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [MEM_W-1:0]   rdata_q [LATENCY];
  logic               done_q;

  // Offset wraps in 32 bits, so addresses below BASE_ADDR land far out of range.
  assign offset_s = mem.mem_addr_i - BASE_ADDR;
  assign idx_s    = offset_s[IDX_W-1:2];
  assign oor_s    = ERR_EN & (|offset_s[31:IDX_W]);
  // Gating with rst_ni keeps requests made during reset from touching storage.
  assign wr_en_s  = rst_ni & mem.mem_req_i & mem.mem_we_i & ~oor_s;
  assign unused_s = ^offset_s[1:0];

  // Response payload for the request presented this cycle.
  always_comb begin
    rsp_err_d   = 1'b0;
    rsp_rdata_d = {MEM_W{1'b0}};
    if (mem.mem_req_i) begin
      if (oor_s) begin
        rsp_err_d = 1'b1;
      end else if (!mem.mem_we_i) begin
        // Byte enables play no part in reads.
        rsp_rdata_d = mem_q[idx_s];
      end else begin
        rsp_rdata_d = {MEM_W{1'b0}};
      end
    end else begin
      rsp_err_d = 1'b0;
    end
  end

  // Byte-masked write into storage on the accepting edge.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 32'd0; b < 32'd4; b++) begin
      if (wr_en_s && mem.mem_be_i[b]) begin
        mem_q[idx_s][8*b +: 8] <= mem.mem_wdata_i[8*b +: 8];
      end
    end
  end

  // Response shift pipeline; reset drops everything still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= {LATENCY{1'b0}};
      err_q <= {LATENCY{1'b0}};
      for (int unsigned i = 32'd0; i < LATENCY; i++) begin
        rdata_q[i] <= {MEM_W{1'b0}};
      end
    end else begin
      vld_q[0]   <= mem.mem_req_i;
      err_q[0]   <= rsp_err_d;
      rdata_q[0] <= rsp_rdata_d;
      for (int unsigned i = 32'd1; i < LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  // Sticky program-end flag: any accepted request to offset 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else if (mem.mem_req_i && (offset_s == 32'h0000_0000)) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done_q;
    end
  end

  // Idle pipeline stages carry zero payload, so outputs are 0 without a response.
  assign mem.mem_rvalid_o = vld_q[LATENCY-1];
  assign mem.mem_err_o    = err_q[LATENCY-1] & ERR_EN;
  assign mem.mem_rdata_o  = rdata_q[LATENCY-1];
  assign done_o           = done_q;

endmodule
